bn_rr_arbiter_8: RTL and testbench
==================================

Name: bn_rr_arbiter_8

Overview:
- Round-robin arbiter for 8 requesters, directly upstream of the 8-way one-hot data select.
- Produces a registered one-hot grant vector that drives the select's sel[7:0]. Exactly one data source, or none, reaches y.
- Grant is held under a valid/ready handshake until the downstream consumer accepts the selected word.
- Priority then rotates so that no requester starves.

Parameters:
- RESET_PTR, 0, index (0..7) of the highest-priority requester after reset.

Ports:
- clk  input  1  system clock, rising-edge active
- rst  input  1  asynchronous reset, active-high
- req  input  8  request per source; bit i means di has data; must stay high until that source is accepted
- gnt_ready  input  1  downstream accepts the selected word this cycle
- gnt  output  8  one-hot grant, or all-zero; drives the one-hot select's sel
- gnt_idx  output  3  binary index of the granted source; 0 when no grant
- gnt_valid  output  1  gnt/gnt_idx hold a live grant

Behaviour:
- Clock and reset: single clock clk; rst is asynchronous, active-high.
- Reset values (asserted asynchronously, released synchronously with clk):
  - gnt = 8'h00, gnt_idx = 3'd0, gnt_valid = 0
  - ptr = RESET_PTR, state = IDLE
- All outputs are registered. No combinational path from inputs to outputs.
- Invariant: gnt is zero or one-hot. gnt_valid == |gnt. gnt_idx is the position of the set bit.
- ptr (3 bits) is the index with highest priority.
- Search order: ptr, ptr+1, ..., ptr+7, all modulo 8. The winner is the first set req bit in that order.
- IDLE:
  - If req == 0: stay in IDLE; outputs remain zero.
  - If req != 0 at a rising edge: load gnt = onehot(winner), gnt_idx = winner, gnt_valid = 1; go to GRANT.
  - Latency: req sampled at edge N; grant visible after edge N.
- GRANT:
  - While gnt_ready == 0: gnt, gnt_idx and gnt_valid are held bit-stable. This applies even if req changes, including the winner's own bit dropping (protocol violation, ignored) or new higher-priority requests arriving.
  - On an edge with gnt_ready == 1, the transfer is accepted: ptr <= gnt_idx + 1 (3-bit wrap, 7 -> 0); gnt <= 0; gnt_valid <= 0; gnt_idx <= 0; go to IDLE.
- Throughput:
  - One mandatory idle cycle after each acceptance, so the peak rate is one grant per 2 cycles.
  - The idle cycle lets the accepted requester drop req before the next arbitration.
- Fairness: the just-served source has lowest priority at the next arbitration. With all 8 requesting continuously, every source is granted once per 8 grants.
- gnt_ready in IDLE is ignored.
- Reset mid-grant: outputs clear immediately. ptr returns to RESET_PTR; it is not preserved.
- A RESET_PTR value outside 0..7 is truncated to 3 bits.

Optional Feature:
- Macro: BN_RR_LOCK_EN
- When defined:
  - Adds input port lock (1 bit). It is sampled on the accepting edge (gnt_valid && gnt_ready).
  - If lock == 1 at acceptance: ptr is unchanged. If the same requester's req is still high in the following IDLE cycle, it wins again regardless of the other requests. This supports multi-beat bursts.
  - If lock == 0 at acceptance: normal rotation.
  - Lock never extends a grant whose req is low; normal search applies.
- When not defined: no lock port; ptr always rotates on acceptance.

Test Plan:
- Reset: assert rst asynchronously mid-cycle with req = 8'hFF -> gnt = 0, gnt_valid = 0, gnt_idx = 0 immediately. After release with RESET_PTR = 0, the first grant is gnt = 8'h01.
- Single requester: req = 8'h10, gnt_ready = 1 -> one cycle later gnt = 8'h10, gnt_idx = 4, gnt_valid = 1. Next cycle cleared. Repeats every 2 cycles while req is held.
- Full rotation: req = 8'hFF constant, gnt_ready = 1 -> grant sequence idx 0,1,2,...,7,0, each separated by one idle cycle.
- Wrap-around: after serving idx 5 (ptr = 6), req = 8'h41 -> idx 6 granted, then idx 0, then idx 6.
- Stall: grant idx 2 active; hold gnt_ready = 0 for 4 cycles while req changes from 8'h04 to 8'h03 -> gnt stays 8'h04 every cycle. Accept on cycle 5; next grant is idx 0, or idx 1 once req bit 2 is low.
- Lock (BN_RR_LOCK_EN): req = 8'h0A, accept idx 1 with lock = 1 -> next grant is idx 1 again. Accept with lock = 0 -> next grant is idx 3.

Source files
------------

// File: rtl/bn_rr_arbiter_8.sv
// Round-robin arbiter for 8 requesters with registered one-hot grant; optional BN_RR_LOCK_EN burst lock.
// Latency: grant one edge after req is sampled; grant held until gnt_ready, then one idle cycle.
module bn_rr_arbiter_8 #(
  parameter int RESET_PTR = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic       gnt_ready,
`ifdef BN_RR_LOCK_EN
  input  logic       lock,
`endif
  output logic [7:0] gnt,
  output logic [2:0] gnt_idx,
  output logic       gnt_valid
);

  localparam logic [2:0] PTR_INIT = 3'(RESET_PTR);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t     state;
  logic [2:0] ptr;
  logic [7:0] rot;
  logic [2:0] off;
  logic [2:0] win;

  // rot[k] is the request k places after ptr; the lowest set bit is the winner.
  always_comb begin
    rot = 8'h00;
    off = 3'd0;
    for (int k = 0; k < 8; k++) begin
      rot[k] = req[ptr + 3'(k)];
    end
    for (int k = 7; k >= 0; k--) begin
      if (rot[k]) off = 3'(k);
    end
    win = ptr + off;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= PTR_INIT;
      gnt       <= 8'h00;
      gnt_idx   <= 3'd0;
      gnt_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            gnt       <= 8'd1 << win;
            gnt_idx   <= win;
            gnt_valid <= 1'b1;
            state     <= GRANT;
          end
        end
        GRANT: begin
          if (gnt_ready) begin
`ifdef BN_RR_LOCK_EN
            // A locked source keeps top priority so its next beat wins if still requesting.
            ptr <= lock ? gnt_idx : gnt_idx + 3'd1;
`else
            ptr <= gnt_idx + 3'd1;
`endif
            gnt       <= 8'h00;
            gnt_idx   <= 3'd0;
            gnt_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bn_rr_arbiter_8.sv
// Directed bench for bn_rr_arbiter_8: expected grants queued per step and checked one edge later.
module tb_bn_rr_arbiter_8;

  logic       clk;
  logic       rst;
  logic [7:0] req;
  logic       gnt_ready;
`ifdef BN_RR_LOCK_EN
  logic       lock;
`endif
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;

  int tests;
  int fails;

  typedef struct packed {
    logic [7:0] g;
    logic [2:0] i;
    logic       v;
  } exp_t;

  exp_t exp_q[$];

  bn_rr_arbiter_8 #(.RESET_PTR(0)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .gnt_ready (gnt_ready),
`ifdef BN_RR_LOCK_EN
    .lock      (lock),
`endif
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input exp_t e);
    exp_t o;
    o = '{g: gnt, i: gnt_idx, v: gnt_valid};
    tests++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s: got gnt=%h idx=%0d vld=%b, want gnt=%h idx=%0d vld=%b",
             tag, o.g, o.i, o.v, e.g, e.i, e.v);
    end
  endtask

  // Queue the expectation for the coming edge, then compare just after it.
  task automatic tick(input string tag, input logic [7:0] g, input logic [2:0] i, input logic v);
    exp_t e;
    exp_q.push_back('{g: g, i: i, v: v});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check(tag, e);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b1;
    req = 8'h00;
    gnt_ready = 1'b0;
`ifdef BN_RR_LOCK_EN
    lock = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", '{g: 8'h00, i: 3'd0, v: 1'b0});
    rst = 1'b0;

    tick("idle_no_req", 8'h00, 3'd0, 1'b0);

    // First grant from reset pointer, then advance pointer before a mid-cycle reset.
    req = 8'hFF;
    gnt_ready = 1'b1;
    tick("first_grant", 8'h01, 3'd0, 1'b1);
    tick("first_accept", 8'h00, 3'd0, 1'b0);
    tick("second_grant", 8'h02, 3'd1, 1'b1);
    #3;
    rst = 1'b1;
    #1;
    check("rst_async_clear", '{g: 8'h00, i: 3'd0, v: 1'b0});
    #1;
    rst = 1'b0;
    tick("rst_ptr_restored", 8'h01, 3'd0, 1'b1);
    tick("rst_ptr_accept", 8'h00, 3'd0, 1'b0);

    // Full rotation with all requesting: 1..7 then 0, idle cycle between grants.
    for (int n = 1; n <= 8; n++) begin
      logic [2:0] k;
      logic [7:0] oh;
      k = 3'(n % 8);
      oh = 8'd1 << k;
      tick("rotation_grant", oh, k, 1'b1);
      tick("rotation_idle", 8'h00, 3'd0, 1'b0);
    end

    // Single requester repeats every two cycles.
    req = 8'h10;
    tick("single_grant_a", 8'h10, 3'd4, 1'b1);
    tick("single_idle_a", 8'h00, 3'd0, 1'b0);
    tick("single_grant_b", 8'h10, 3'd4, 1'b1);
    tick("single_idle_b", 8'h00, 3'd0, 1'b0);

    // Wrap-around: serve idx 5 so ptr = 6, then 8'h41 gives 6, 0, 6.
    req = 8'h20;
    tick("serve_5", 8'h20, 3'd5, 1'b1);
    tick("serve_5_idle", 8'h00, 3'd0, 1'b0);
    req = 8'h41;
    tick("wrap_6", 8'h40, 3'd6, 1'b1);
    tick("wrap_idle_a", 8'h00, 3'd0, 1'b0);
    tick("wrap_0", 8'h01, 3'd0, 1'b1);
    tick("wrap_idle_b", 8'h00, 3'd0, 1'b0);
    tick("wrap_6_again", 8'h40, 3'd6, 1'b1);
    tick("wrap_idle_c", 8'h00, 3'd0, 1'b0);

    // Stall: grant idx 2 held while req changes and gnt_ready stays low.
    req = 8'h04;
    gnt_ready = 1'b0;
    tick("stall_grant", 8'h04, 3'd2, 1'b1);
    req = 8'h03;
    for (int n = 0; n < 4; n++) begin
      tick("stall_hold", 8'h04, 3'd2, 1'b1);
    end
    gnt_ready = 1'b1;
    tick("stall_accept", 8'h00, 3'd0, 1'b0);
    tick("after_stall_0", 8'h01, 3'd0, 1'b1);
    tick("after_stall_idle", 8'h00, 3'd0, 1'b0);
    tick("after_stall_1", 8'h02, 3'd1, 1'b1);
    tick("after_stall_idle2", 8'h00, 3'd0, 1'b0);

    // Ready in IDLE with no request must not create a grant.
    req = 8'h00;
    tick("idle_ready_ignored", 8'h00, 3'd0, 1'b0);
    tick("idle_ready_ignored2", 8'h00, 3'd0, 1'b0);

`ifdef BN_RR_LOCK_EN
    // ptr = 2 here: 8'h0A picks idx 3; locked acceptance re-grants it, unlocked rotates to 1.
    req = 8'h0A;
    lock = 1'b1;
    tick("lock_first", 8'h08, 3'd3, 1'b1);
    tick("lock_accept", 8'h00, 3'd0, 1'b0);
    tick("lock_regrant", 8'h08, 3'd3, 1'b1);
    lock = 1'b0;
    tick("unlock_accept", 8'h00, 3'd0, 1'b0);
    tick("unlock_rotate", 8'h02, 3'd1, 1'b1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
